// File: rtl/dual_ram_be.sv
// dual_ram_be: simple dual-port RAM (one write port, one read port, one clock)
// with per-byte write enables, write-first forwarding on same-address
// collisions, a 1- or 2-cycle read pipeline with a valid strobe, and an
// optional zero-fill sweep after reset.
module dual_ram_be #(
  parameter int DW      = 32,
  parameter int AW      = 12,
  parameter int MEM_NUM = 4096,
  parameter int RD_LAT  = 1,
  parameter int CLR_EN  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            w_en,
  input  logic [DW/8-1:0] w_be_i,
  input  logic [AW-1:0]   w_addr_i,
  input  logic [DW-1:0]   w_data_i,
  input  logic            r_en,
  input  logic [AW-1:0]   r_addr_i,
  output logic [DW-1:0]   r_data_o,
  output logic            r_valid_o,
  output logic            init_done_o
);

  localparam int NB = DW / 8;
  localparam int IW = (MEM_NUM > 1) ? $clog2(MEM_NUM) : 1;

  typedef enum logic [1:0] {IDLE_RST, CLEAR, READY} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] clr_cnt;
  logic          clr_active;
  logic          init_done;
  logic          init_done_nxt;

  logic [DW-1:0] mem [0:MEM_NUM-1];

  logic          w_in_range;
  logic          r_in_range;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] r_idx;
  logic          do_write;
  logic          do_read;
  logic [DW-1:0] rd_word;

  logic [DW-1:0] s1_data;
  logic          s1_valid;

  assign w_in_range = (32'(w_addr_i) < MEM_NUM);
  assign r_in_range = (32'(r_addr_i) < MEM_NUM);
  assign w_idx      = w_addr_i[IW-1:0];
  assign r_idx      = r_addr_i[IW-1:0];
  assign do_write   = init_done && w_en && w_in_range;
  assign do_read    = init_done && r_en;

  // State register: reset parks the FSM in IDLE_RST.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE_RST;
    else        state <= state_nxt;
  end

  // Next state: optional clear sweep, then READY until the next reset.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE_RST: state_nxt = (CLR_EN != 0) ? CLEAR : READY;
      CLEAR:    if (clr_cnt == IW'(MEM_NUM - 1)) state_nxt = READY;
      READY:    state_nxt = READY;
      default:  state_nxt = IDLE_RST;
    endcase
  end

  // FSM outputs: sweep enable now, ready flag registered from the next state.
  always_comb begin
    clr_active    = (state == CLEAR);
    init_done_nxt = (state_nxt == READY);
  end

  // Clear address counter and registered ready flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else begin
      init_done <= init_done_nxt;
      if (clr_active) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // Memory array: zero-fill during the sweep, otherwise byte-masked writes.
  always_ff @(posedge clk) begin
    if (clr_active) begin
      mem[clr_cnt] <= '0;
    end else if (do_write) begin
      for (int k = 0; k < NB; k++) begin
        if (w_be_i[k]) mem[w_idx][8*k +: 8] <= w_data_i[8*k +: 8];
      end
    end
  end

  // Read word with write-first forwarding of enabled lanes on a collision.
  always_comb begin
    rd_word = '0;
    if (r_in_range) begin
      rd_word = mem[r_idx];
      if (do_write && (w_idx == r_idx)) begin
        for (int k = 0; k < NB; k++) begin
          if (w_be_i[k]) rd_word[8*k +: 8] = w_data_i[8*k +: 8];
        end
      end
    end
  end

  // First read stage: data only loads on an accepted read so it holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= do_read;
      if (do_read) s1_data <= rd_word;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DW-1:0] s2_data;
      logic          s2_valid;

      // Second read stage for the two-cycle latency option.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) s2_data <= s1_data;
        end
      end

      assign r_data_o  = s2_data;
      assign r_valid_o = s2_valid;
    end else begin : g_lat1
      assign r_data_o  = s1_data;
      assign r_valid_o = s1_valid;
    end
  endgenerate

  assign init_done_o = init_done;

endmodule

// File: tb/tb_dual_ram_be.sv
// tb_dual_ram_be: scoreboard bench for dual_ram_be. Instance A uses
// RD_LAT=1 with the clear sweep; instance B uses RD_LAT=2, no sweep and a
// 5-bit address so out-of-range accesses can be exercised.
module tb_dual_ram_be;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk;
  int   cyc;
  int   total;
  int   bad;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a;
  exp_t e_b;

  logic        a_rst_n, a_w_en, a_r_en, a_r_valid, a_init_done;
  logic [3:0]  a_w_be, a_w_addr, a_r_addr;
  logic [31:0] a_w_data, a_r_data;

  logic        b_rst_n, b_w_en, b_r_en, b_r_valid, b_init_done;
  logic [3:0]  b_w_be;
  logic [4:0]  b_w_addr, b_r_addr;
  logic [31:0] b_w_data, b_r_data;

  dual_ram_be #(.DW(32), .AW(4), .MEM_NUM(16), .RD_LAT(1), .CLR_EN(1)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .w_en(a_w_en), .w_be_i(a_w_be),
    .w_addr_i(a_w_addr), .w_data_i(a_w_data), .r_en(a_r_en),
    .r_addr_i(a_r_addr), .r_data_o(a_r_data), .r_valid_o(a_r_valid),
    .init_done_o(a_init_done)
  );

  dual_ram_be #(.DW(32), .AW(5), .MEM_NUM(16), .RD_LAT(2), .CLR_EN(0)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .w_en(b_w_en), .w_be_i(b_w_be),
    .w_addr_i(b_w_addr), .w_data_i(b_w_data), .r_en(b_r_en),
    .r_addr_i(b_r_addr), .r_data_o(b_r_data), .r_valid_o(b_r_valid),
    .init_done_o(b_init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp expected read results.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drive one cycle of requests on instance A (sel=0) or B (sel=1) and queue the expected read.
  task automatic applyStimulus(input int sel, input logic w, input logic [3:0] be,
                               input logic [4:0] waddr, input logic [31:0] wdata,
                               input logic r, input logic [4:0] raddr, input logic [31:0] rexp);
    @(negedge clk);
    if (sel == 0) begin
      a_w_en = w; a_w_be = be; a_w_addr = waddr[3:0]; a_w_data = wdata;
      a_r_en = r; a_r_addr = raddr[3:0];
      if (r) q_a.push_back('{data: rexp, due: cyc + 1});
    end else begin
      b_w_en = w; b_w_be = be; b_w_addr = waddr; b_w_data = wdata;
      b_r_en = r; b_r_addr = raddr;
      if (r) q_b.push_back('{data: rexp, due: cyc + 2});
    end
  endtask

  task automatic wr(input int sel, input logic [4:0] addr, input logic [31:0] data, input logic [3:0] be);
    applyStimulus(sel, 1'b1, be, addr, data, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic rd(input int sel, input logic [4:0] addr, input logic [31:0] exp);
    applyStimulus(sel, 1'b0, 4'd0, 5'd0, 32'd0, 1'b1, addr, exp);
  endtask

  task automatic idle(input int sel);
    applyStimulus(sel, 1'b0, 4'd0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Hold reset on A for n edges, then check the reset-state outputs.
  task automatic resetA(input int n);
    @(negedge clk);
    a_rst_n = 1'b0;
    repeat (n - 1) @(negedge clk);
    checkOutput("a_rst_valid", 32'(a_r_valid), 32'd0);
    checkOutput("a_rst_data", a_r_data, 32'd0);
    checkOutput("a_rst_init_done", 32'(a_init_done), 32'd0);
  endtask

  // Release A's reset and check init_done low for 16 cycles, high on the 17th.
  task automatic initTimingA();
    a_rst_n = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      checkOutput($sformatf("a_init_done_c%0d", i), 32'(a_init_done), (i == 17) ? 32'd1 : 32'd0);
    end
  endtask

  // Scoreboard monitor for instance A.
  always @(negedge clk) begin
    if (a_r_valid === 1'b1) begin
      if (q_a.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL a_unexpected_valid actual=%h required=no_valid", a_r_data);
      end else begin
        e_a = q_a.pop_front();
        checkOutput("a_read_data", a_r_data, e_a.data);
        checkOutput("a_read_cycle", 32'(cyc), 32'(e_a.due));
      end
    end
  end

  // Scoreboard monitor for instance B.
  always @(negedge clk) begin
    if (b_r_valid === 1'b1) begin
      if (q_b.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL b_unexpected_valid actual=%h required=no_valid", b_r_data);
      end else begin
        e_b = q_b.pop_front();
        checkOutput("b_read_data", b_r_data, e_b.data);
        checkOutput("b_read_cycle", 32'(cyc), 32'(e_b.due));
      end
    end
  end

  initial begin
    cyc = 0; total = 0; bad = 0;
    a_rst_n = 1'b0; a_w_en = 1'b0; a_r_en = 1'b0; a_w_be = '0; a_w_addr = '0; a_w_data = '0; a_r_addr = '0;
    b_rst_n = 1'b0; b_w_en = 1'b0; b_r_en = 1'b0; b_w_be = '0; b_w_addr = '0; b_w_data = '0; b_r_addr = '0;

    // Instance A: first reset and clear, then preload all ones.
    resetA(3);
    initTimingA();
    for (int i = 0; i < 16; i++) wr(0, 5'(i), 32'hFFFF_FFFF, 4'hF);
    rd(0, 5'd0, 32'hFFFF_FFFF);
    rd(0, 5'd15, 32'hFFFF_FFFF);
    idle(0);

    // Second reset: the sweep must zero every preloaded word.
    resetA(2);
    initTimingA();
    for (int i = 0; i < 16; i++) rd(0, 5'(i), 32'h0);
    idle(0);

    // Byte enables and read-after-write.
    wr(0, 5'd3, 32'h1122_3344, 4'b1111);
    wr(0, 5'd3, 32'hAABB_CCDD, 4'b0101);
    rd(0, 5'd3, 32'h11BB_33DD);

    // Same-address collision merges new and old lanes.
    wr(0, 5'd5, 32'h0102_0304, 4'hF);
    applyStimulus(0, 1'b1, 4'b1100, 5'd5, 32'hA0B0_C0D0, 1'b1, 5'd5, 32'hA0B0_0304);
    rd(0, 5'd5, 32'hA0B0_0304);

    // Different addresses in the same cycle are independent; be=0 is a no-op.
    applyStimulus(0, 1'b1, 4'hF, 5'd6, 32'hCAFE_F00D, 1'b1, 5'd3, 32'h11BB_33DD);
    rd(0, 5'd6, 32'hCAFE_F00D);
    wr(0, 5'd6, 32'hFFFF_FFFF, 4'b0000);
    rd(0, 5'd6, 32'hCAFE_F00D);

    // Back-to-back reads with one-cycle latency.
    wr(0, 5'd0, 32'hC000_0000, 4'hF);
    wr(0, 5'd1, 32'hC000_0001, 4'hF);
    wr(0, 5'd2, 32'hC000_0002, 4'hF);
    rd(0, 5'd0, 32'hC000_0000);
    rd(0, 5'd1, 32'hC000_0001);
    rd(0, 5'd2, 32'hC000_0002);
    idle(0);

    // Reset in the middle of the sweep, with requests held during the restart.
    @(negedge clk);
    a_rst_n = 1'b0;
    @(negedge clk);
    a_rst_n = 1'b1;
    repeat (8) @(negedge clk);
    a_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    a_w_en = 1'b1; a_w_be = 4'hF; a_w_addr = 4'd2; a_w_data = 32'hDEAD_BEEF;
    a_r_en = 1'b1; a_r_addr = 4'd2;
    initTimingA();
    a_w_en = 1'b0; a_r_en = 1'b0; a_w_be = '0;
    for (int i = 0; i < 16; i++) rd(0, 5'(i), 32'h0);
    idle(0);

    // Instance B: no sweep, ready one cycle after release.
    @(negedge clk);
    b_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("b_rst_valid", 32'(b_r_valid), 32'd0);
    checkOutput("b_rst_data", b_r_data, 32'd0);
    checkOutput("b_rst_init_done", 32'(b_init_done), 32'd0);
    b_rst_n = 1'b1;
    @(negedge clk);
    checkOutput("b_init_done_c1", 32'(b_init_done), 32'd1);

    // Two-cycle latency, back-to-back reads.
    wr(1, 5'd0, 32'h0A0A_0A0A, 4'hF);
    wr(1, 5'd1, 32'h1B1B_1B1B, 4'hF);
    wr(1, 5'd2, 32'h2C2C_2C2C, 4'hF);
    rd(1, 5'd0, 32'h0A0A_0A0A);
    rd(1, 5'd1, 32'h1B1B_1B1B);
    rd(1, 5'd2, 32'h2C2C_2C2C);
    idle(1);

    // Out-of-range write dropped, out-of-range read returns zero.
    wr(1, 5'd0, 32'h1234_5678, 4'hF);
    wr(1, 5'd16, 32'hFFFF_FFFF, 4'hF);
    rd(1, 5'd16, 32'h0);
    rd(1, 5'd0, 32'h1234_5678);

    // Collision through the two-stage pipeline.
    applyStimulus(1, 1'b1, 4'b0011, 5'd0, 32'hAABB_CCDD, 1'b1, 5'd0, 32'h1234_CCDD);
    rd(1, 5'd0, 32'h1234_CCDD);
    idle(1);

    repeat (6) @(negedge clk);
    checkOutput("a_queue_empty", 32'(q_a.size()), 32'd0);
    checkOutput("b_queue_empty", 32'(q_b.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dual_ram_be.md
Name: dual_ram_be

Overview:
- Parametrised next-generation simple dual-port RAM: one write port, one read port, one clock.
- Adds four features:
  - per-byte write enables;
  - write-to-read forwarding on same-address collisions;
  - selectable read latency of 1 or 2 cycles, with a read-valid strobe;
  - optional hardware clear sequence after reset.
- Used as instruction/data memory and as general scratch storage behind the core's memory bus.

Parameters:
- DW, 32, data width in bits; must be a multiple of 8.
- AW, 12, address width.
- MEM_NUM, 4096, number of words; must satisfy MEM_NUM <= 2^AW.
- RD_LAT, 1, read latency in cycles; legal values are 1 and 2.
- CLR_EN, 1, 1 = zero every word after reset release; 0 = no clear.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- w_en  input  1  write request.
- w_be_i  input  DW/8  byte enables; bit k covers data bits [8k+7:8k].
- w_addr_i  input  AW  write word address.
- w_data_i  input  DW  write data.
- r_en  input  1  read request.
- r_addr_i  input  AW  read word address.
- r_data_o  output  DW  read data.
- r_valid_o  output  1  r_data_o carries the result of a read issued RD_LAT cycles earlier.
- init_done_o  output  1  RAM ready; requests are honoured only while high.

Behaviour:
- Reset (rst_n low at a rising edge):
  - r_data_o=0, r_valid_o=0, init_done_o=0.
  - Read pipeline is flushed; FSM goes to IDLE_RST.
  - Memory contents are not reset directly.
- FSM states and transitions:
  - IDLE_RST: entered while in reset. First cycle with rst_n high moves to CLEAR if CLR_EN=1, else to READY.
  - CLEAR: clr_cnt starts at 0. Each cycle writes all-zero to memory[clr_cnt] and increments clr_cnt. The cycle that writes MEM_NUM-1 moves to READY.
    - Duration is exactly MEM_NUM cycles.
    - w_en and r_en are ignored; no r_valid_o pulses.
    - Reset asserted mid-CLEAR aborts the sweep; the next release restarts it from address 0.
  - READY: init_done_o=1. The FSM stays here until reset.
- init_done_o is registered:
  - CLR_EN=0: rises exactly 1 cycle after rst_n release.
  - CLR_EN=1: rises MEM_NUM+1 cycles after rst_n release.
- Write (READY, w_en=1, w_addr_i<MEM_NUM): at the clock edge, each byte lane with w_be_i[k]=1 takes w_data_i's lane; other lanes keep their value.
  - w_be_i=0 is a legal no-op.
  - w_addr_i>=MEM_NUM: write dropped silently.
- Read (READY, r_en=1):
  - Word is sampled at the edge where r_en is high.
  - r_addr_i>=MEM_NUM returns 0.
  - RD_LAT=1: r_data_o/r_valid_o update at the same edge; visible in the following cycle.
  - RD_LAT=2: one further register stage; visible 2 cycles after the request.
  - Back-to-back reads give one result per cycle, fully pipelined.
- r_valid_o:
  - High for exactly one cycle per accepted read.
  - Low otherwise.
- r_data_o holds its last value while r_valid_o=0; it is not cleared.
- Collision (r_en and w_en in the same cycle, same in-range address): returned word is a per-lane merge.
  - Lanes with w_be_i=1 return the new w_data_i byte.
  - Lanes with w_be_i=0 return the old stored byte (write-first forwarding).
  - Different addresses: fully independent.
- Read-after-write: a read issued the cycle after a write returns the written data.
- Requests arriving while init_done_o=0 are discarded, never queued.

Test Plan:
Bench configuration for all scenarios: DW=32, AW=4, MEM_NUM=16 unless noted.
- Reset/clear, CLR_EN=1:
  - Preload memory with 0xFFFFFFFF and release rst_n.
  - Required: init_done_o=0 for cycles 1..16 after release, 1 at cycle 17.
  - Read all 16 addresses -> each returns 0x00000000 with r_valid_o 1 cycle after r_en.
- Byte enables:
  - Write 0x11223344 to addr 3 with be=4'b1111.
  - Then write 0xAABBCCDD to addr 3 with be=4'b0101.
  - Read addr 3 -> 0x11BB33DD.
- Collision:
  - With addr 5 holding 0x01020304, issue in one cycle: w_en, addr 5, data 0xA0B0C0D0, be=4'b1100, plus r_en, addr 5.
  - Required: r_data_o=0xA0B00304.
  - A following read of addr 5 also returns 0xA0B00304.
- Latency, RD_LAT=2:
  - Reads of addrs 0,1,2 on consecutive cycles.
  - Required: r_valid_o high on cycles +2,+3,+4 with matching data, then low.
  - With RD_LAT=1 the same stimulus gives valid on +1,+2,+3.
- Gating:
  - w_en/r_en asserted during CLEAR -> no memory change, no r_valid_o.
  - Write to addr 16 with MEM_NUM=16, AW=5 -> dropped; read of addr 16 -> 0.
- Reset mid-clear:
  - Assert rst_n low at clear cycle 8, release 3 cycles later.
  - Required: init_done_o rises 17 cycles after the second release; all words read 0.
